// File: rtl/bike_trail_writer.sv
// Trail painter: writes the trail segment behind the bike, or fills the frame.
// Ports: clock/resetn; tick/location/orient/colour in; clear_req/bg_color in;
// mem_req/mem_gnt arbitration; mem_we/mem_addr/mem_wdata out; busy/done status.
// Optional macro TRAIL_PENDING_EN: one-deep pending tick captured while busy.
module bike_trail_writer #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BIKE_HALF = 16,
    parameter int TRAIL_W   = 3,
    parameter int STEP      = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        tick,
    input  logic [18:0] bikeLocation_middle,
    input  logic [2:0]  bike_orient,
    input  logic [23:0] trail_color,
    input  logic        clear_req,
    input  logic [23:0] bg_color,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [23:0] mem_wdata,
    output logic        busy,
    output logic        done
);

    localparam int HALF  = (TRAIL_W - 1) / 2;
    localparam int FRAME = SCREEN_W * SCREEN_H;
    localparam int DMAX  = (TRAIL_W > STEP) ? TRAIL_W : STEP;
    localparam int CW    = $clog2(DMAX + 1);

    localparam logic [18:0] FRAME_L = 19'(FRAME);
    localparam logic [18:0] STRIDE  = 19'(SCREEN_W);
    // Base offsets from the bike centre, as modulo-2^19 addends.
    localparam logic [18:0] OFF_UP = 19'(BIKE_HALF * SCREEN_W - HALF);
    localparam logic [18:0] OFF_LT = 19'(BIKE_HALF - HALF * SCREEN_W);
    localparam logic [18:0] OFF_DN =
        19'(-((BIKE_HALF + STEP - 1) * SCREEN_W) - HALF);
    localparam logic [18:0] OFF_RT =
        19'(-BIKE_HALF - (STEP - 1) - HALF * SCREEN_W);
    localparam logic [CW-1:0] TW_M1 = CW'(TRAIL_W - 1);
    localparam logic [CW-1:0] ST_M1 = CW'(STEP - 1);

    typedef enum logic [1:0] {IDLE, SEG, CLR, FIN} state_t;

    state_t state, state_n;

    logic [18:0]   row_base;
    logic [CW-1:0] col, row, wx_m1, hy_m1;
    logic [23:0]   color;

    logic          tick_ok, load, clr_start, fin_go, advance, last_pix, pix_ok;
    logic [18:0]   cur_addr;
    logic [18:0]   src_mid;
    logic [1:0]    src_orient;
    logic [23:0]   src_color;
    logic [18:0]   g_base;
    logic [CW-1:0] g_wx_m1, g_hy_m1;

    assign tick_ok = tick & ~bike_orient[2];

`ifdef TRAIL_PENDING_EN
    logic        pend_valid;
    logic [18:0] pend_mid;
    logic [1:0]  pend_orient;
    logic [23:0] pend_color;

    // A tick arriving in the same cycle is newer than the stored entry.
    assign src_mid    = tick_ok ? bikeLocation_middle : pend_mid;
    assign src_orient = tick_ok ? bike_orient[1:0] : pend_orient;
    assign src_color  = tick_ok ? trail_color : pend_color;
    assign fin_go     = tick_ok | pend_valid;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend_valid  <= 1'b0;
            pend_mid    <= '0;
            pend_orient <= '0;
            pend_color  <= '0;
        end else if (clear_req || load) begin
            pend_valid <= 1'b0;
        end else if (state != IDLE && tick_ok) begin
            pend_valid  <= 1'b1;
            pend_mid    <= bikeLocation_middle;
            pend_orient <= bike_orient[1:0];
            pend_color  <= trail_color;
        end
    end
`else
    assign src_mid    = bikeLocation_middle;
    assign src_orient = bike_orient[1:0];
    assign src_color  = trail_color;
    assign fin_go     = 1'b0;
`endif

    always_comb begin
        g_base  = src_mid + OFF_UP;
        g_wx_m1 = TW_M1;
        g_hy_m1 = ST_M1;
        case (src_orient)
            2'd0: begin
                g_base  = src_mid + OFF_UP;
                g_wx_m1 = TW_M1;
                g_hy_m1 = ST_M1;
            end
            2'd1: begin
                g_base  = src_mid + OFF_LT;
                g_wx_m1 = ST_M1;
                g_hy_m1 = TW_M1;
            end
            2'd2: begin
                g_base  = src_mid + OFF_DN;
                g_wx_m1 = TW_M1;
                g_hy_m1 = ST_M1;
            end
            default: begin
                g_base  = src_mid + OFF_RT;
                g_wx_m1 = ST_M1;
                g_hy_m1 = TW_M1;
            end
        endcase
    end

    // In CLR the column stays 0, so row_base is the linear address.
    assign cur_addr = row_base + 19'(col);
    assign pix_ok   = cur_addr < FRAME_L;
    assign last_pix = (state == CLR) ? (row_base == FRAME_L - 19'd1)
                                     : (col == wx_m1 && row == hy_m1);
    assign advance  = (state == SEG || state == CLR) && mem_gnt && !clear_req;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        clr_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n   = CLR;
                    clr_start = 1'b1;
                end else if (tick_ok) begin
                    state_n = SEG;
                    load    = 1'b1;
                end
            end
            SEG, CLR: begin
                if (clear_req) begin
                    state_n   = CLR;
                    clr_start = 1'b1;
                end else if (mem_gnt && last_pix) begin
                    state_n = FIN;
                end
            end
            FIN: begin
                if (clear_req) begin
                    state_n   = CLR;
                    clr_start = 1'b1;
                end else if (fin_go) begin
                    state_n = SEG;
                    load    = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_req = (state == SEG) || (state == CLR);
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            row_base  <= '0;
            col       <= '0;
            row       <= '0;
            wx_m1     <= '0;
            hy_m1     <= '0;
            color     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (advance) begin
                // Clipped pixels still use their granted slot.
                mem_we    <= pix_ok;
                mem_addr  <= cur_addr;
                mem_wdata <= color;
            end
            if (load) begin
                row_base <= g_base;
                col      <= '0;
                row      <= '0;
                wx_m1    <= g_wx_m1;
                hy_m1    <= g_hy_m1;
                color    <= src_color;
            end else if (clr_start) begin
                row_base <= '0;
                col      <= '0;
                row      <= '0;
                color    <= bg_color;
            end else if (advance && !last_pix) begin
                if (state == CLR) begin
                    row_base <= row_base + 19'd1;
                end else if (col == wx_m1) begin
                    col      <= '0;
                    row      <= row + CW'(1);
                    row_base <= row_base + STRIDE;
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bike_trail_writer.sv
// Directed self-checking bench for bike_trail_writer.
// A second instance with a short frame covers the complete-clear boundary.
module tb_bike_trail_writer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        tick;
    logic [18:0] mid;
    logic [2:0]  orient;
    logic [23:0] tcol;
    logic        clear_req;
    logic [23:0] bg;
    logic        gnt;

    logic        mem_req, mem_we, busy, done;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata;

    logic        s_clear;
    logic        s_req, s_we, s_busy, s_done;
    logic [18:0] s_addr;
    logic [23:0] s_wdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    bike_trail_writer u_dut (
        .clock(clock), .resetn(resetn), .tick(tick),
        .bikeLocation_middle(mid), .bike_orient(orient),
        .trail_color(tcol), .clear_req(clear_req), .bg_color(bg),
        .mem_req(mem_req), .mem_gnt(gnt), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done)
    );

    bike_trail_writer #(.SCREEN_H(48)) u_small (
        .clock(clock), .resetn(resetn), .tick(tick),
        .bikeLocation_middle(mid), .bike_orient(orient),
        .trail_color(tcol), .clear_req(s_clear), .bg_color(bg),
        .mem_req(s_req), .mem_gnt(gnt), .mem_we(s_we),
        .mem_addr(s_addr), .mem_wdata(s_wdata),
        .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int exp_a, bad, writes, dones, done_k, first_a, last_a;
        resetn = 1'b1; tick = 0; mid = '0; orient = '0; tcol = '0;
        clear_req = 0; bg = '0; gnt = 1'b1; s_clear = 0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        step(); step();
        resetn = 1'b1;
        step();

        // Up: base 164159, 3 wide x 4 tall.
        tick = 1; mid = 19'd153920; orient = 3'd0; tcol = 24'hABCDEF;
        step();
        tick = 0;
        chk("up_busy", busy, 1);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_a = 164159 + (k / 3) * 640 + (k % 3);
            chk("up_addr", mem_addr, exp_a);
            if (mem_we !== 1'b1 || mem_wdata !== 24'hABCDEF) bad++;
        end
        chk("up_we_data", bad, 0);
        chk("up_last", mem_addr, 166081);
        chk("up_done", done, 1);
        step();
        chk("up_done_end", done, 0);
        chk("up_busy_end", busy, 0);

        // Left with alternating grant: base 153296, 4 wide x 3 tall.
        tick = 1; mid = 19'd153920; orient = 3'd1; tcol = 24'h112233;
        step();
        tick = 0;
        bad = 0; writes = 0; done_k = 0;
        for (int k = 1; k <= 40; k++) begin
            gnt = k[0];
            step();
            if (mem_we !== gnt) bad++;
            if (mem_we === 1'b1) begin
                exp_a = 153296 + (writes / 4) * 640 + (writes % 4);
                if (mem_addr !== 19'(exp_a)) bad++;
                writes++;
            end
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        gnt = 1'b1;
        chk("left_we_addr", bad, 0);
        chk("left_writes", writes, 12);
        chk("left_done_k", done_k, 23);
        step();
        chk("left_idle", busy, 0);

        // Down near top: base wraps, every pixel clipped.
        tick = 1; mid = 19'd6500; orient = 3'd2;
        step();
        tick = 0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (mem_we !== 1'b0) bad++;
            if (k < 11 && done !== 1'b0) bad++;
        end
        chk("down_no_we", bad, 0);
        chk("down_done", done, 1);
        step();
        chk("down_idle", busy, 0);

        // Invalid orientation is ignored.
        tick = 1; orient = 3'd5;
        step();
        tick = 0;
        chk("inv_busy", busy, 0);
        step();
        chk("inv_done", done, 0);

        // Reset in the middle of a clear.
        bg = 24'h0C1530;
        clear_req = 1;
        step();
        clear_req = 0;
        for (int k = 0; k < 1000; k++) step();
        chk("clr_addr999", mem_addr, 999);
        chk("clr_we", mem_we, 1);
        #2 resetn = 1'b0;
        #1;
        chk("mrst_we", mem_we, 0);
        chk("mrst_req", mem_req, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_addr", mem_addr, 0);
        step();
        resetn = 1'b1;
        clear_req = 1;
        step();
        clear_req = 0;
        step();
        chk("reclr_addr", mem_addr, 0);
        chk("reclr_data", mem_wdata, 24'h0C1530);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();

        // Full clear on the 640x48 instance, tick on the same edge dropped.
        s_clear = 1; tick = 1; mid = 19'd20000; orient = 3'd0;
        step();
        s_clear = 0; tick = 0;
        bad = 0; writes = 0; dones = 0; last_a = -1;
        for (int k = 0; k < 30725; k++) begin
            step();
            if (s_we === 1'b1) begin
                if (s_addr !== 19'(writes) || s_wdata !== 24'h0C1530) bad++;
                last_a = int'(s_addr);
                writes++;
            end
            if (s_done === 1'b1) dones++;
        end
        chk("fill_addr_data", bad, 0);
        chk("fill_writes", writes, 30720);
        chk("fill_last", last_a, 30719);
        chk("fill_done_once", dones, 1);
        chk("fill_idle", s_busy, 0);

        // Second tick while a segment is in flight.
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        tick = 1; mid = 19'd153920; orient = 3'd3;
        step();
        tick = 0;
        writes = 0; dones = 0; first_a = -1;
        for (int k = 0; k < 45; k++) begin
            if (k == 3) begin
                tick = 1; orient = 3'd0;
            end else begin
                tick = 0;
            end
            step();
            if (mem_we === 1'b1) begin
                if (first_a < 0) first_a = int'(mem_addr);
                writes++;
            end
            if (done === 1'b1) dones++;
        end
        chk("right_first", first_a, 153261);
`ifdef TRAIL_PENDING_EN
        chk("pend_dones", dones, 2);
        chk("pend_writes", writes, 24);
`else
        chk("drop_dones", dones, 1);
        chk("drop_writes", writes, 12);
`endif
        chk("end_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bike_trail_writer.md
Name: bike_trail_writer

Overview:
- Write-side partner of the per-pixel collision check that reads background/frame memory at the scan address.
- On each bike move tick, paints the trail segment behind the bike into frame memory.
- On round start, fills the whole frame with the background colour.
- Shares the frame-memory write port with other masters through a req/gnt pair. Linear addressing is addr = y*SCREEN_W + x.

Parameters:
SCREEN_W, 640, pixels per row (address stride)
SCREEN_H, 480, rows; frame size FRAME = SCREEN_W*SCREEN_H = 307200
BIKE_HALF, 16, distance from bike middle to its tail edge
TRAIL_W, 3, trail thickness in pixels (odd); HALF = (TRAIL_W-1)/2
STEP, 4, trail length in pixels painted per tick

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
tick  in  1  one-cycle pulse: bike moved; latch location/orient/colour
bikeLocation_middle  in  19  linear address of bike centre
bike_orient  in  3  0=up, 1=left, 2=down, 3=right; 4-7 invalid
trail_color  in  24  RGB trail colour
clear_req  in  1  one-cycle pulse: fill frame with bg_color
bg_color  in  24  background fill colour
mem_req  out  1  request write port
mem_gnt  in  1  write port granted this cycle
mem_we  out  1  write strobe (registered)
mem_addr  out  19  write address (registered)
mem_wdata  out  24  write data (registered)
busy  out  1  segment or clear in progress
done  out  1  one-cycle pulse at end of segment/clear

Behaviour:
- Reset (async, resetn=0): state IDLE; mem_req, mem_we, busy, done = 0; mem_addr = 0; mem_wdata = 0; pending cleared.
- States:
  - IDLE: tick with valid orient -> SEG; clear_req -> CLR.
  - SEG and CLR: mem_req=1, busy=1.
  - FIN: done=1, busy=1, mem_req=0; returns to IDLE next edge.
- Segment rectangle, base address B, width Wx, height Hy:
  - up: B = mid + BIKE_HALF*SCREEN_W - HALF; Wx=TRAIL_W, Hy=STEP
  - down: B = mid - (BIKE_HALF+STEP-1)*SCREEN_W - HALF; Wx=TRAIL_W, Hy=STEP
  - left: B = mid + BIKE_HALF - HALF*SCREEN_W; Wx=STEP, Hy=TRAIL_W
  - right: B = mid - BIKE_HALF - (STEP-1) - HALF*SCREEN_W; Wx=STEP, Hy=TRAIL_W
- Scan order: row-major. Column counter c in 0..Wx-1; row base advances by SCREEN_W per row. Use no multiplier and no divider. Arithmetic is 19-bit modulo 2^19.
- Clipping: a pixel with computed addr >= FRAME (including underflow wrap) still consumes a granted cycle, with mem_we=0. No horizontal clipping.
- Write timing:
  - At each rising edge in SEG/CLR with mem_gnt=1: mem_we=1, mem_addr/mem_wdata = current pixel, and the counter advances.
  - With mem_gnt=0: mem_we=0 and no advance.
  - The edge that issues the last pixel moves to FIN.
- Latency: with gnt held high, tick sampled at edge 0 gives writes at edges 1..N (N=Wx*Hy), done at edge N+1, and IDLE at edge N+2.
- CLR: writes addr 0..FRAME-1 with bg_color, one per granted cycle.
- Simultaneous events:
  - tick and clear_req together: clear wins, tick dropped.
  - clear_req during SEG: segment aborted, CLR starts from addr 0 next edge.
  - clear_req during CLR: restart at 0.
  - tick during SEG/CLR/FIN: dropped, unless the optional feature below is compiled in.
  - tick with orient 4-7: ignored, no done.
- Inputs are sampled only on the accepting tick; later changes do not affect the segment in flight.

Optional Feature:
- Macro: TRAIL_PENDING_EN.
- When defined:
  - A one-deep pending register captures a valid tick arriving while busy. A newer tick overwrites it.
  - FIN proceeds directly to SEG with the pending values; done still pulses.
  - clear_req discards the pending entry.
- When undefined: ticks arriving while busy are dropped.

Test Plan:
- Reset mid-CLR (resetn low at write 1000): all outputs 0 immediately, IDLE; next clear_req restarts at addr 0.
- Tick, mid=153920, orient=0, gnt=1: 12 writes, addr 164159,164160,164161,164799,...,166081; done at edge 13; busy low at edge 14.
- Tick, mid=153920, orient=1, gnt toggling 1/0: 12 writes, addr 153296..153299, 153936..153939, 154576..154579; mem_we only on gnt cycles; done after 24 cycles.
- Tick, mid=6500, orient=2, gnt=1: B wraps; 12 granted cycles with mem_we=0 throughout; done at edge 13.
- clear_req with gnt=1, bg_color=0x0C1530: 307200 writes, addr 0..307199, data 0x0C1530; tick at the same edge dropped; done once.
- TRAIL_PENDING_EN: tick during SEG (orient=3) -> second segment starts right after FIN; two done pulses. Without the macro -> one done, second tick lost.
